// File: rtl/glide_controller.sv
// glide_controller: produces the registered phase_inc word for a phase
// accumulator. A new target increment is accepted over valid/ready, and
// phase_inc ramps linearly toward it by glide_step per tick. Arrival is
// clamped, so the ramp never overshoots, overflows or underflows.
module glide_controller #(
    parameter int ACC_WIDTH = 32,
    parameter int TICK_DIV  = 1,
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 target_valid,
    output logic                 target_ready,
    input  logic [ACC_WIDTH-1:0] target_inc,
    input  logic [ACC_WIDTH-1:0] glide_step,
    input  logic                 glide_abort,
    output logic [ACC_WIDTH-1:0] phase_inc,
    output logic                 gliding,
    output logic                 done
);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GLIDE = 1'b1;

    // Last prescaler value; the cycle holding it is a glide tick.
    localparam logic [DIV_WIDTH-1:0] TICK_LAST = DIV_WIDTH'(TICK_DIV - 1);

    logic                 state_q, state_d;
    logic [ACC_WIDTH-1:0] phase_inc_q, phase_inc_d;
    logic [ACC_WIDTH-1:0] target_q, target_d;
    logic [ACC_WIDTH-1:0] step_q, step_d;
    logic [DIV_WIDTH-1:0] presc_q, presc_d;
    logic                 done_q, done_d;

    logic                 tick;
    logic                 target_above;
    logic [ACC_WIDTH-1:0] diff;

    assign target_ready = (state_q == ST_IDLE);
    assign gliding      = (state_q == ST_GLIDE);
    assign phase_inc    = phase_inc_q;
    assign done         = done_q;

    // Distance to the target as an unsigned magnitude, plus the tick strobe.
    always_comb begin
        tick         = (presc_q == TICK_LAST);
        target_above = (target_q > phase_inc_q);
        diff         = target_above ? (target_q - phase_inc_q)
                                    : (phase_inc_q - target_q);
    end

    // Next-state logic: accept in IDLE, step/clamp/abort in GLIDE.
    always_comb begin
        state_d     = state_q;
        phase_inc_d = phase_inc_q;
        target_d    = target_q;
        step_d      = step_q;
        presc_d     = presc_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (target_valid) begin
                    target_d = target_inc;
                    step_d   = glide_step;
                    presc_d  = '0;
                    if ((glide_step == '0) || (target_inc == phase_inc_q)) begin
                        phase_inc_d = target_inc;
                        done_d      = 1'b1;
                    end else begin
                        state_d = ST_GLIDE;
                    end
                end
            end
            default: begin
                if (glide_abort) begin
                    // Abort takes priority over a tick in the same cycle.
                    phase_inc_d = target_q;
                    state_d     = ST_IDLE;
                    done_d      = 1'b1;
                end else begin
                    presc_d = tick ? '0 : presc_q + DIV_WIDTH'(1);
                    if (tick) begin
                        if (diff <= step_q) begin
                            phase_inc_d = target_q;
                            state_d     = ST_IDLE;
                            done_d      = 1'b1;
                        end else if (target_above) begin
                            phase_inc_d = phase_inc_q + step_q;
                        end else begin
                            phase_inc_d = phase_inc_q - step_q;
                        end
                    end
                end
            end
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            phase_inc_q <= '0;
            target_q    <= '0;
            step_q      <= '0;
            presc_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_inc_q <= phase_inc_d;
            target_q    <= target_d;
            step_q      <= step_d;
            presc_q     <= presc_d;
            done_q      <= done_d;
        end
    end

endmodule
